decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline. It sits between the fetch stage's IF/ID registers and the execute stage.
- Decodes the instruction, reads the register file and generates the immediate.
- Resolves branches, JAL and JALR in ID and drives the next-PC select and targets back to fetch.
- Detects data hazards and drives fetch stall/flush. Registers all execute-stage control and data in the ID/EX register.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count; register index width is 5.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pc_decode  in  XLEN  PC from the IF/ID register
- instr_decode  in  32  instruction from the IF/ID register
- pc_sel  out  PC_SEL_WIDTH  next-PC select to fetch
- br_decode  out  XLEN  branch target
- jal_decode  out  XLEN  JAL target
- jalr_decode  out  XLEN  JALR target
- stall_if  out  1  hold PC and IF/ID
- flush_if  out  1  squash the IF/ID instruction
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination register
- wb_data  in  XLEN  writeback data
- mem_rd  in  5  EX/MEM destination register
- mem_reg_write  in  1  EX/MEM writes a register
- mem_mem_read  in  1  EX/MEM holds a load
- mem_alu_data  in  XLEN  EX/MEM ALU result (forwarding source)
- pc_ex, rs1_data_ex, rs2_data_ex, imm_ex  out  XLEN  ID/EX data
- rs1_ex, rs2_ex, rd_ex  out  5  ID/EX register indices
- alu_op_ex  out  ALU_OP_WIDTH  ALU operation
- alu_src_a_ex  out  1  ALU operand A select: 0=rs1, 1=pc
- alu_src_b_ex  out  1  ALU operand B select: 0=rs2, 1=imm
- mem_read_ex, mem_write_ex, reg_write_ex  out  1  ID/EX control
- funct3_ex  out  3  memory access size/sign
- wb_sel_ex  out  2  writeback source: ALU / MEM / PC+4

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-low.
- Reset:
  - While rst_n=0 on an edge, every ID/EX output becomes 0, which is a bubble with reg_write_ex=0.
  - While rst_n=0, pc_sel=PC_SEL_PC4, stall_if=0 and flush_if=0 combinationally.
  - All register-file entries reset to 0.
- Decode:
  - Decode is combinational from instr_decode. The ID/EX register updates on every posedge; latency is 1 cycle.
  - instr_decode==0 is a NOP and produces a bubble. Fetch inserts this value on a flush.
  - Illegal or unsupported opcodes also produce a bubble. No trap is raised.
- Immediates: formats I/S/B/U/J are sign-extended to XLEN. imm_ex carries the selected immediate.
- Register file:
  - 2 read ports, 1 write port. Reads are combinational.
  - Write-through: when wb_we=1, wb_rd==rs and rs!=0, the read returns wb_data in the same cycle.
  - x0 reads 0 and writes to x0 are ignored.
- ID operand forwarding (used for the branch compare, the JALR base and rs*_data_ex):
  - Priority 1: if mem_reg_write=1, mem_mem_read=0, mem_rd!=0 and mem_rd==rs, the operand is mem_alu_data.
  - Priority 2: otherwise the register file with write-through.
- Hazards, with stall_if=1 and a bubble into ID/EX:
  - (a) Load-use: mem_read_ex=1, rd_ex!=0 and rd_ex matches a used rs.
  - (b) Branch or JALR whose used rs matches rd_ex while reg_write_ex=1 and rd_ex!=0.
  - (c) Branch or JALR whose used rs matches mem_rd while mem_mem_read=1 and mem_rd!=0.
  - "Used" is per opcode: U and J types use no rs; I type and JALR use rs1 only.
- Redirect:
  - Branch taken (BEQ/BNE/BLT/BGE/BLTU/BGEU on forwarded operands): pc_sel=PC_SEL_BRANCH, br_decode=pc+immB.
  - JAL: pc_sel=PC_SEL_JAL, jal_decode=pc+immJ.
  - JALR: pc_sel=PC_SEL_JALR, jalr_decode=(rs1+immI)&~1.
  - Otherwise pc_sel=PC_SEL_PC4.
  - Target arithmetic is modulo 2^XLEN.
  - br_decode, jal_decode and jalr_decode are always driven with their computed value, even when not selected.
- flush_if = (pc_sel != PC_SEL_PC4) and not stall_if.
- Simultaneous redirect and stall: the stall wins. pc_sel is forced to PC_SEL_PC4 and flush_if=0; the redirect is taken on the cycle the hazard clears.
- Control-flow instructions in EX:
  - The branch itself enters ID/EX with reg_write_ex=0.
  - JAL and JALR enter ID/EX with wb_sel_ex=PC+4 and reg_write_ex=(rd!=0).

Decomposition:
- Add the following to constants.vh:
  - PC_SEL_WIDTH=2, with PC_SEL_PC4=0, PC_SEL_BRANCH=1, PC_SEL_JAL=2, PC_SEL_JALR=3.
  - Opcode constants.
  - ALU_OP_WIDTH and ALU_OP_* encodings.
  - WB_SEL_* encodings.
  - IMM_* format codes.
- One sub-module, regfile (2R1W, write-through, x0 hardwired to 0).
- The immediate generator, hazard logic and comparator remain inline.

Test Plan:
- Reset, then release: all ID/EX outputs 0 and pc_sel=PC4. With wb_we=1, wb_rd=5, wb_data=0x1234 and "add x6,x5,x0" in ID on the same cycle, rs1_data_ex=0x1234 next cycle.
- "beq x1,x2,+16" at pc=0x100 with x1=x2=7 -> pc_sel=BRANCH, br_decode=0x110, flush_if=1, bubble in ID/EX. With x2=8 -> pc_sel=PC4, flush_if=0.
- "lw x3,0(x1)" then "add x4,x3,x3" -> one cycle with stall_if=1 and a bubble (reg_write_ex=0); the add enters ID/EX on the following cycle.
- "addi x1,x0,5" then "jalr x1,3(x1)" -> one stall cycle; then, with mem_alu_data=5 forwarded, jalr_decode=0x8, pc_sel=JALR, rd_ex=1, wb_sel_ex=PC+4.
- "jal x0,-8" at pc=0x4 -> jal_decode=0xFFFFFFFC (wraps), reg_write_ex=0. instr_decode=0 -> bubble. Undefined opcode 0x7F -> bubble.
- rst_n=0 asserted while a load-use stall is active -> after the edge ID/EX is 0 and stall_if=0; the write to x0 from the previous cycle has no effect.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_pkg
//  Description : Shared encodings for the RV32I decode stage: next-PC select,
//                opcodes, ALU operations, writeback sources and immediate
//                formats.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    // Next-PC select driven back to fetch
    localparam int PC_SEL_WIDTH = 2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL    = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR   = 2'd3;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU operations
    localparam int ALU_OP_WIDTH = 4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD    = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB    = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL    = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT    = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU   = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR    = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL    = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA    = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR     = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND    = 4'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_PASS_B = 4'd10;

    // Writeback source
    localparam int WB_SEL_WIDTH = 2;
    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_ALU = 2'd0;
    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_MEM = 2'd1;
    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_PC4 = 2'd2;

    // Immediate formats
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Shared funct3 -> ALU op mapping for OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [ALU_OP_WIDTH-1:0] alu_op_decode(input logic [2:0] funct3,
                                                              input logic       alt);
        logic [ALU_OP_WIDTH-1:0] op;
        case (funct3)
            3'd0:    op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'd1:    op = ALU_OP_SLL;
            3'd2:    op = ALU_OP_SLT;
            3'd3:    op = ALU_OP_SLTU;
            3'd4:    op = ALU_OP_XOR;
            3'd5:    op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'd6:    op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_regfile
//  Description : 2-read / 1-write architectural register file. Reads are
//                combinational with write-through of the same-cycle
//                writeback; x0 always reads zero and ignores writes.
//  Ports       : clk, rst_n (sync, active-low, clears all entries)
//                i_rs1_addr/i_rs2_addr -> o_rs1_data/o_rs2_data
//                i_we, i_rd, i_wd      : write port
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_we,
    input  logic [AW-1:0]   i_rd,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_rd != '0)) begin
            r_regs[i_rd] <= i_wd;
        end
    end

    always_comb begin
        o_rs1_data = '0;
        if (i_rs1_addr != '0) begin
            o_rs1_data = (i_we && (i_rd == i_rs1_addr)) ? i_wd : r_regs[i_rs1_addr];
        end
    end

    always_comb begin
        o_rs2_data = '0;
        if (i_rs2_addr != '0) begin
            o_rs2_data = (i_we && (i_rd == i_rs2_addr)) ? i_wd : r_regs[i_rs2_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : ID stage of the 5-stage RV32I pipeline. Decodes the IF/ID
//                instruction, reads the register file, builds immediates,
//                resolves branches/JAL/JALR, detects hazards and registers
//                execute-stage control/data in the ID/EX register.
//  Ports       : clk, rst_n (sync, active-low)
//                pc_decode, instr_decode         : from IF/ID
//                pc_sel, br/jal/jalr_decode      : redirect to fetch
//                stall_if, flush_if              : fetch control
//                wb_we, wb_rd, wb_data           : writeback port
//                mem_rd, mem_reg_write, mem_mem_read, mem_alu_data : EX/MEM
//                *_ex                            : ID/EX register outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [XLEN-1:0]         pc_decode,
    input  logic [31:0]             instr_decode,
    output logic [PC_SEL_WIDTH-1:0] pc_sel,
    output logic [XLEN-1:0]         br_decode,
    output logic [XLEN-1:0]         jal_decode,
    output logic [XLEN-1:0]         jalr_decode,
    output logic                    stall_if,
    output logic                    flush_if,
    input  logic                    wb_we,
    input  logic [4:0]              wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic [4:0]              mem_rd,
    input  logic                    mem_reg_write,
    input  logic                    mem_mem_read,
    input  logic [XLEN-1:0]         mem_alu_data,
    output logic [XLEN-1:0]         pc_ex,
    output logic [XLEN-1:0]         rs1_data_ex,
    output logic [XLEN-1:0]         rs2_data_ex,
    output logic [XLEN-1:0]         imm_ex,
    output logic [4:0]              rs1_ex,
    output logic [4:0]              rs2_ex,
    output logic [4:0]              rd_ex,
    output logic [ALU_OP_WIDTH-1:0] alu_op_ex,
    output logic                    alu_src_a_ex,
    output logic                    alu_src_b_ex,
    output logic                    mem_read_ex,
    output logic                    mem_write_ex,
    output logic                    reg_write_ex,
    output logic [2:0]              funct3_ex,
    output logic [WB_SEL_WIDTH-1:0] wb_sel_ex
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = instr_decode[6:0];
    assign w_rd     = instr_decode[11:7];
    assign w_funct3 = instr_decode[14:12];
    assign w_rs1    = instr_decode[19:15];
    assign w_rs2    = instr_decode[24:20];
    assign w_funct7 = instr_decode[31:25];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic                    w_legal;
    logic                    w_use_rs1;
    logic                    w_use_rs2;
    imm_fmt_e                w_imm_fmt;
    logic [ALU_OP_WIDTH-1:0] w_alu_op;
    logic                    w_alu_src_a;
    logic                    w_alu_src_b;
    logic                    w_mem_read;
    logic                    w_mem_write;
    logic                    w_reg_write;
    logic [WB_SEL_WIDTH-1:0] w_wb_sel;
    logic                    w_is_branch;
    logic                    w_is_jal;
    logic                    w_is_jalr;

    always_comb begin
        w_legal     = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_imm_fmt   = IMM_NONE;
        w_alu_op    = ALU_OP_ADD;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = WB_SEL_ALU;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;

        case (w_opcode)
            OPC_LUI: begin
                w_legal     = 1'b1;
                w_imm_fmt   = IMM_U;
                w_alu_op    = ALU_OP_PASS_B;
                w_alu_src_b = 1'b1;
                w_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_legal     = 1'b1;
                w_imm_fmt   = IMM_U;
                w_alu_src_a = 1'b1;
                w_alu_src_b = 1'b1;
                w_reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_legal     = 1'b1;
                w_is_jal    = 1'b1;
                w_imm_fmt   = IMM_J;
                w_alu_src_a = 1'b1;
                w_alu_src_b = 1'b1;
                w_reg_write = (w_rd != 5'd0);
                w_wb_sel    = WB_SEL_PC4;
            end
            OPC_JALR: begin
                w_legal     = (w_funct3 == 3'd0);
                w_is_jalr   = 1'b1;
                w_use_rs1   = 1'b1;
                w_imm_fmt   = IMM_I;
                w_alu_src_b = 1'b1;
                w_reg_write = (w_rd != 5'd0);
                w_wb_sel    = WB_SEL_PC4;
            end
            OPC_BRANCH: begin
                w_legal     = (w_funct3 != 3'd2) && (w_funct3 != 3'd3);
                w_is_branch = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_imm_fmt   = IMM_B;
            end
            OPC_LOAD: begin
                w_legal     = (w_funct3 != 3'd3) && (w_funct3 != 3'd6) && (w_funct3 != 3'd7);
                w_use_rs1   = 1'b1;
                w_imm_fmt   = IMM_I;
                w_alu_src_b = 1'b1;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
                w_wb_sel    = WB_SEL_MEM;
            end
            OPC_STORE: begin
                w_legal     = (w_funct3 <= 3'd2);
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_imm_fmt   = IMM_S;
                w_alu_src_b = 1'b1;
                w_mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // Shift-immediates constrain funct7; SRAI is the only alternate form
                if (w_funct3 == 3'd1)
                    w_legal = (w_funct7 == 7'h00);
                else if (w_funct3 == 3'd5)
                    w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                else
                    w_legal = 1'b1;
                w_use_rs1   = 1'b1;
                w_imm_fmt   = IMM_I;
                w_alu_src_b = 1'b1;
                w_alu_op    = alu_op_decode(w_funct3, (w_funct3 == 3'd5) && w_funct7[5]);
                w_reg_write = 1'b1;
            end
            OPC_OP: begin
                w_legal     = (w_funct7 == 7'h00) ||
                              ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)));
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_alu_op    = alu_op_decode(w_funct3, w_funct7[5]);
                w_reg_write = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        // Illegal encodings (including the all-zero NOP) must neither stall
        // nor redirect; they simply become a bubble.
        if (!w_legal) begin
            w_use_rs1   = 1'b0;
            w_use_rs2   = 1'b0;
            w_is_branch = 1'b0;
            w_is_jal    = 1'b0;
            w_is_jalr   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm;

    assign w_imm_i = XLEN'($signed(instr_decode[31:20]));
    assign w_imm_s = XLEN'($signed({instr_decode[31:25], instr_decode[11:7]}));
    assign w_imm_b = XLEN'($signed({instr_decode[31], instr_decode[7],
                                    instr_decode[30:25], instr_decode[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({instr_decode[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({instr_decode[31], instr_decode[19:12],
                                    instr_decode[20], instr_decode[30:21], 1'b0}));

    always_comb begin
        w_imm = '0;
        case (w_imm_fmt)
            IMM_I:   w_imm = w_imm_i;
            IMM_S:   w_imm = w_imm_s;
            IMM_B:   w_imm = w_imm_b;
            IMM_U:   w_imm = w_imm_u;
            IMM_J:   w_imm = w_imm_j;
            default: w_imm = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file and ID-stage forwarding
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rf_rs1;
    logic [XLEN-1:0] w_rf_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_mem_fwd_ok;

    decode_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rf_rs1),
        .o_rs2_data (w_rf_rs2),
        .i_we       (wb_we),
        .i_rd       (wb_rd),
        .i_wd       (wb_data)
    );

    // A load in EX/MEM has no data yet, so only ALU results are forwarded
    assign w_mem_fwd_ok = mem_reg_write && !mem_mem_read && (mem_rd != 5'd0);
    assign w_fwd_rs1    = (w_mem_fwd_ok && (mem_rd == w_rs1)) ? mem_alu_data : w_rf_rs1;
    assign w_fwd_rs2    = (w_mem_fwd_ok && (mem_rd == w_rs2)) ? mem_alu_data : w_rf_rs2;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_ctrl_uses_rs;
    logic w_haz_load_use;
    logic w_haz_ex;
    logic w_haz_mem;

    assign w_ctrl_uses_rs = w_is_branch || w_is_jalr;

    assign w_haz_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                            ((w_use_rs1 && (w_rs1 == rd_ex)) || (w_use_rs2 && (w_rs2 == rd_ex)));

    assign w_haz_ex       = w_ctrl_uses_rs && reg_write_ex && (rd_ex != 5'd0) &&
                            ((w_use_rs1 && (w_rs1 == rd_ex)) || (w_use_rs2 && (w_rs2 == rd_ex)));

    assign w_haz_mem      = w_ctrl_uses_rs && mem_mem_read && (mem_rd != 5'd0) &&
                            ((w_use_rs1 && (w_rs1 == mem_rd)) || (w_use_rs2 && (w_rs2 == mem_rd)));

    assign stall_if = rst_n && (w_haz_load_use || w_haz_ex || w_haz_mem);

    // ------------------------------------------------------------------
    // Branch resolution and redirect
    // ------------------------------------------------------------------
    logic                    w_br_taken;
    logic [XLEN-1:0]         w_jalr_sum;
    logic [PC_SEL_WIDTH-1:0] w_redirect;

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'd0:    w_br_taken = (w_fwd_rs1 == w_fwd_rs2);
            3'd1:    w_br_taken = (w_fwd_rs1 != w_fwd_rs2);
            3'd4:    w_br_taken = ($signed(w_fwd_rs1) <  $signed(w_fwd_rs2));
            3'd5:    w_br_taken = ($signed(w_fwd_rs1) >= $signed(w_fwd_rs2));
            3'd6:    w_br_taken = (w_fwd_rs1 <  w_fwd_rs2);
            3'd7:    w_br_taken = (w_fwd_rs1 >= w_fwd_rs2);
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum  = w_fwd_rs1 + w_imm_i;
    assign br_decode   = pc_decode + w_imm_b;
    assign jal_decode  = pc_decode + w_imm_j;
    assign jalr_decode = {w_jalr_sum[XLEN-1:1], 1'b0};

    always_comb begin
        w_redirect = PC_SEL_PC4;
        if (w_is_jal)
            w_redirect = PC_SEL_JAL;
        else if (w_is_jalr)
            w_redirect = PC_SEL_JALR;
        else if (w_is_branch && w_br_taken)
            w_redirect = PC_SEL_BRANCH;
    end

    // A stalled redirect is held off until the hazard clears
    assign pc_sel   = (!rst_n || stall_if) ? PC_SEL_PC4 : w_redirect;
    assign flush_if = (pc_sel != PC_SEL_PC4) && !stall_if;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    // Branches are fully resolved here, so they carry nothing useful to EX
    logic w_bubble;
    assign w_bubble = stall_if || !w_legal || w_is_branch;

    always_ff @(posedge clk) begin
        if (!rst_n || w_bubble) begin
            pc_ex        <= '0;
            rs1_data_ex  <= '0;
            rs2_data_ex  <= '0;
            imm_ex       <= '0;
            rs1_ex       <= '0;
            rs2_ex       <= '0;
            rd_ex        <= '0;
            alu_op_ex    <= '0;
            alu_src_a_ex <= 1'b0;
            alu_src_b_ex <= 1'b0;
            mem_read_ex  <= 1'b0;
            mem_write_ex <= 1'b0;
            reg_write_ex <= 1'b0;
            funct3_ex    <= '0;
            wb_sel_ex    <= '0;
        end else begin
            pc_ex        <= pc_decode;
            rs1_data_ex  <= w_use_rs1 ? w_fwd_rs1 : '0;
            rs2_data_ex  <= w_use_rs2 ? w_fwd_rs2 : '0;
            imm_ex       <= w_imm;
            // Unused sources are zeroed so EX forwarding never matches them
            rs1_ex       <= w_use_rs1 ? w_rs1 : 5'd0;
            rs2_ex       <= w_use_rs2 ? w_rs2 : 5'd0;
            rd_ex        <= w_reg_write ? w_rd : 5'd0;
            alu_op_ex    <= w_alu_op;
            alu_src_a_ex <= w_alu_src_a;
            alu_src_b_ex <= w_alu_src_b;
            mem_read_ex  <= w_mem_read;
            mem_write_ex <= w_mem_write;
            reg_write_ex <= w_reg_write;
            funct3_ex    <= w_funct3;
            wb_sel_ex    <= w_wb_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int XLEN = 32;

    logic              clk;
    logic              rst_n;
    logic [XLEN-1:0]   pc_decode;
    logic [31:0]       instr_decode;
    logic [1:0]        pc_sel;
    logic [XLEN-1:0]   br_decode, jal_decode, jalr_decode;
    logic              stall_if, flush_if;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [4:0]        mem_rd;
    logic              mem_reg_write, mem_mem_read;
    logic [XLEN-1:0]   mem_alu_data;
    logic [XLEN-1:0]   pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]        rs1_ex, rs2_ex, rd_ex;
    logic [3:0]        alu_op_ex;
    logic              alu_src_a_ex, alu_src_b_ex;
    logic              mem_read_ex, mem_write_ex, reg_write_ex;
    logic [2:0]        funct3_ex;
    logic [1:0]        wb_sel_ex;

    logic [156:0]      w_idex;
    assign w_idex = {pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
                     alu_op_ex, alu_src_a_ex, alu_src_b_ex, mem_read_ex, mem_write_ex,
                     reg_write_ex, funct3_ex, wb_sel_ex};

    int total = 0;
    int bad   = 0;

    decode_stage #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_decode    (pc_decode),
        .instr_decode (instr_decode),
        .pc_sel       (pc_sel),
        .br_decode    (br_decode),
        .jal_decode   (jal_decode),
        .jalr_decode  (jalr_decode),
        .stall_if     (stall_if),
        .flush_if     (flush_if),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .mem_alu_data (mem_alu_data),
        .pc_ex        (pc_ex),
        .rs1_data_ex  (rs1_data_ex),
        .rs2_data_ex  (rs2_data_ex),
        .imm_ex       (imm_ex),
        .rs1_ex       (rs1_ex),
        .rs2_ex       (rs2_ex),
        .rd_ex        (rd_ex),
        .alu_op_ex    (alu_op_ex),
        .alu_src_a_ex (alu_src_a_ex),
        .alu_src_b_ex (alu_src_b_ex),
        .mem_read_ex  (mem_read_ex),
        .mem_write_ex (mem_write_ex),
        .reg_write_ex (reg_write_ex),
        .funct3_ex    (funct3_ex),
        .wb_sel_ex    (wb_sel_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, well away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pc_decode = 32'h40;
        instr_decode = 32'h00500093;            // addi x1,x0,5
        tick();
        tick();
        total++; if (w_idex !== '0) begin bad++; $display("FAIL reset_idex: got %h want 0", w_idex); end
        instr_decode = 32'hFF9FF06F;            // jal x0,-8
        #1;
        total++; if (pc_sel !== PC_SEL_PC4) begin bad++; $display("FAIL reset_pc_sel: got %0d want 0", pc_sel); end
        total++; if ({stall_if, flush_if} !== 2'b00) begin bad++; $display("FAIL reset_stall_flush: got %b want 00", {stall_if, flush_if}); end
        // Release, with write-through of x5 on the same cycle as add x6,x5,x0
        rst_n = 1'b1;
        pc_decode = 32'h44;
        instr_decode = 32'h00028333;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        total++; if (rs1_data_ex !== 32'h1234) begin bad++; $display("FAIL wt_rs1_data: got %h want 00001234", rs1_data_ex); end
        total++; if ({rd_ex, reg_write_ex} !== {5'd6, 1'b1}) begin bad++; $display("FAIL add_rd_we: got %h want %h", {rd_ex, reg_write_ex}, {5'd6, 1'b1}); end
        total++; if (pc_ex !== 32'h44) begin bad++; $display("FAIL add_pc_ex: got %h want 00000044", pc_ex); end
        instr_decode = 32'h0;
        tick();
    endtask

    task automatic test_branch();
        instr_decode = 32'h0;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        tick();
        wb_rd = 5'd2;
        tick();
        wb_we = 1'b0;
        pc_decode = 32'h100;
        instr_decode = 32'h00208863;            // beq x1,x2,+16
        #1;
        total++; if (pc_sel !== PC_SEL_BRANCH) begin bad++; $display("FAIL beq_taken_sel: got %0d want 1", pc_sel); end
        total++; if (br_decode !== 32'h110) begin bad++; $display("FAIL beq_target: got %h want 00000110", br_decode); end
        total++; if ({flush_if, stall_if} !== 2'b10) begin bad++; $display("FAIL beq_flush: got %b want 10", {flush_if, stall_if}); end
        tick();
        total++; if (w_idex !== '0) begin bad++; $display("FAIL beq_bubble: got %h want 0", w_idex); end
        // x2 becomes 8 via same-cycle write-through: not taken
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd8;
        #1;
        total++; if ({pc_sel, flush_if} !== {PC_SEL_PC4, 1'b0}) begin bad++; $display("FAIL beq_not_taken: got %b want 000", {pc_sel, flush_if}); end
        total++; if (br_decode !== 32'h110) begin bad++; $display("FAIL beq_target_driven: got %h want 00000110", br_decode); end
        wb_we = 1'b0;
        instr_decode = 32'h0;
        tick();
    endtask

    task automatic test_load_use();
        pc_decode = 32'h120;
        instr_decode = 32'h0000A183;            // lw x3,0(x1)
        tick();
        total++; if ({mem_read_ex, rd_ex, wb_sel_ex} !== {1'b1, 5'd3, 2'd1}) begin bad++; $display("FAIL lw_idex: got %h want %h", {mem_read_ex, rd_ex, wb_sel_ex}, {1'b1, 5'd3, 2'd1}); end
        pc_decode = 32'h124;
        instr_decode = 32'h00318233;            // add x4,x3,x3
        #1;
        total++; if ({stall_if, flush_if} !== 2'b10) begin bad++; $display("FAIL loaduse_stall: got %b want 10", {stall_if, flush_if}); end
        tick();
        total++; if (w_idex !== '0) begin bad++; $display("FAIL loaduse_bubble: got %h want 0", w_idex); end
        total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL loaduse_release: got %b want 0", stall_if); end
        tick();
        total++; if ({rd_ex, rs1_ex, rs2_ex, reg_write_ex, mem_read_ex} !== {5'd4, 5'd3, 5'd3, 1'b1, 1'b0}) begin bad++; $display("FAIL add_after_stall: got %h want %h", {rd_ex, rs1_ex, rs2_ex, reg_write_ex, mem_read_ex}, {5'd4, 5'd3, 5'd3, 1'b1, 1'b0}); end
        instr_decode = 32'h0;
        tick();
    endtask

    task automatic test_jalr();
        pc_decode = 32'h200;
        instr_decode = 32'h00500093;            // addi x1,x0,5
        tick();
        total++; if ({rd_ex, reg_write_ex, imm_ex} !== {5'd1, 1'b1, 32'd5}) begin bad++; $display("FAIL addi_idex: got %h want %h", {rd_ex, reg_write_ex, imm_ex}, {5'd1, 1'b1, 32'd5}); end
        pc_decode = 32'h204;
        instr_decode = 32'h003080E7;            // jalr x1,3(x1)
        #1;
        total++; if ({stall_if, flush_if, pc_sel} !== {1'b1, 1'b0, PC_SEL_PC4}) begin bad++; $display("FAIL jalr_stall: got %b want 1000", {stall_if, flush_if, pc_sel}); end
        tick();
        total++; if (reg_write_ex !== 1'b0) begin bad++; $display("FAIL jalr_bubble: got %b want 0", reg_write_ex); end
        // addi now in EX/MEM; x1 in the regfile still holds 7
        mem_rd = 5'd1; mem_reg_write = 1'b1; mem_mem_read = 1'b0; mem_alu_data = 32'd5;
        #1;
        total++; if ({stall_if, flush_if, pc_sel} !== {1'b0, 1'b1, PC_SEL_JALR}) begin bad++; $display("FAIL jalr_redirect: got %b want 0111", {stall_if, flush_if, pc_sel}); end
        total++; if (jalr_decode !== 32'h8) begin bad++; $display("FAIL jalr_target: got %h want 00000008", jalr_decode); end
        tick();
        total++; if ({rd_ex, wb_sel_ex, reg_write_ex, rs1_data_ex} !== {5'd1, 2'd2, 1'b1, 32'd5}) begin bad++; $display("FAIL jalr_idex: got %h want %h", {rd_ex, wb_sel_ex, reg_write_ex, rs1_data_ex}, {5'd1, 2'd2, 1'b1, 32'd5}); end
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_alu_data = 32'd0;
        instr_decode = 32'h0;
        tick();
    endtask

    task automatic test_jal_and_bubbles();
        pc_decode = 32'h4;
        instr_decode = 32'hFF9FF06F;            // jal x0,-8
        #1;
        total++; if (jal_decode !== 32'hFFFFFFFC) begin bad++; $display("FAIL jal_target_wrap: got %h want fffffffc", jal_decode); end
        total++; if ({pc_sel, flush_if} !== {PC_SEL_JAL, 1'b1}) begin bad++; $display("FAIL jal_sel: got %b want 101", {pc_sel, flush_if}); end
        tick();
        total++; if ({reg_write_ex, wb_sel_ex, rd_ex, pc_ex} !== {1'b0, 2'd2, 5'd0, 32'h4}) begin bad++; $display("FAIL jal_idex: got %h want %h", {reg_write_ex, wb_sel_ex, rd_ex, pc_ex}, {1'b0, 2'd2, 5'd0, 32'h4}); end
        pc_decode = 32'h300;
        instr_decode = 32'h0;
        tick();
        total++; if (w_idex !== '0) begin bad++; $display("FAIL nop_bubble: got %h want 0", w_idex); end
        instr_decode = 32'h0000007F;
        #1;
        total++; if ({pc_sel, stall_if, flush_if} !== 4'b0000) begin bad++; $display("FAIL illegal_ctrl: got %b want 0000", {pc_sel, stall_if, flush_if}); end
        tick();
        total++; if (w_idex !== '0) begin bad++; $display("FAIL illegal_bubble: got %h want 0", w_idex); end
        instr_decode = 32'h0;
        tick();
    endtask

    task automatic test_reset_during_stall();
        pc_decode = 32'h400;
        instr_decode = 32'h0000A183;            // lw x3,0(x1)
        tick();
        instr_decode = 32'h00318233;            // add x4,x3,x3
        #1;
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL rst_pre_stall: got %b want 1", stall_if); end
        rst_n = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        #1;
        total++; if ({stall_if, flush_if, pc_sel} !== 4'b0000) begin bad++; $display("FAIL rst_stall_drop: got %b want 0000", {stall_if, flush_if, pc_sel}); end
        tick();
        total++; if (w_idex !== '0) begin bad++; $display("FAIL rst_stall_idex: got %h want 0", w_idex); end
        rst_n = 1'b1;
        wb_we = 1'b0;
        instr_decode = 32'h000003B3;            // add x7,x0,x0
        tick();
        total++; if ({rs1_data_ex, rd_ex} !== {32'd0, 5'd7}) begin bad++; $display("FAIL x0_read: got %h want %h", {rs1_data_ex, rd_ex}, {32'd0, 5'd7}); end
        instr_decode = 32'h00028333;            // add x6,x5,x0 - x5 cleared by reset
        tick();
        total++; if (rs1_data_ex !== 32'd0) begin bad++; $display("FAIL rf_cleared: got %h want 0", rs1_data_ex); end
    endtask

    initial begin
        rst_n = 1'b0;
        pc_decode = '0;
        instr_decode = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_alu_data = '0;
        #1;
        test_reset();
        test_branch();
        test_load_use();
        test_jalr();
        test_jal_and_bubbles();
        test_reset_during_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
